// File: rtl/kernel_run_length_decode.sv
// Run-length decoder: expands a 16-bit token stream into pixels.
// A nonzero token is a literal pixel; token 0 is followed by a count N
// that expands to N zero pixels. Frames are pixelCount pixels long.
module kernel_run_length_decode #(
  parameter int pixelCount = 1600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] input_S1,
  input  logic        avail_S1,
  output logic        read_S1,
  output logic [15:0] output_S2,
  output logic        write_S2,
  input  logic        full_S2,
  output logic        running,
  output logic        frame_done,
  output logic        err
);

  localparam logic [15:0] PIX_LAST = 16'(pixelCount);

  typedef enum logic [1:0] {
    RD_TOK    = 2'd0,
    RD_CNT    = 2'd1,
    EMIT_LIT  = 2'd2,
    EMIT_ZERO = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] lit_r;
  logic [15:0] run_cnt;
  logic [15:0] pix_cnt;
  logic        rd_state;
  logic        emit_state;
  logic        frame_end;

  // Strobe and data decode from the current state; reset masks both strobes.
  always_comb begin
    rd_state   = (state == RD_TOK) || (state == RD_CNT);
    emit_state = (state == EMIT_LIT) || (state == EMIT_ZERO);
    read_S1    = !rst && rd_state && avail_S1;
    write_S2   = !rst && emit_state && !full_S2;
    if (state == EMIT_LIT) begin
      output_S2 = lit_r;
    end else begin
      output_S2 = 16'd0;
    end
    frame_end  = write_S2 && ((pix_cnt + 16'd1) == PIX_LAST);
  end

  // Decoder FSM, counters and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RD_TOK;
      lit_r      <= 16'd0;
      run_cnt    <= 16'd0;
      pix_cnt    <= 16'd0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      running    <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      if (rd_state) begin
        running <= avail_S1;
      end else begin
        running <= 1'b1;
      end

      case (state)
        RD_TOK: begin
          if (read_S1) begin
            if (input_S1 != 16'd0) begin
              lit_r <= input_S1;
              state <= EMIT_LIT;
            end else begin
              state <= RD_CNT;
            end
          end
        end
        RD_CNT: begin
          if (read_S1) begin
            if (input_S1 != 16'd0) begin
              run_cnt <= input_S1;
              state   <= EMIT_ZERO;
            end else begin
              // A zero-length run is malformed: flag it and emit nothing.
              err   <= 1'b1;
              state <= RD_TOK;
            end
          end
        end
        EMIT_LIT: begin
          if (write_S2) begin
            state <= RD_TOK;
          end
        end
        EMIT_ZERO: begin
          if (write_S2) begin
            if (run_cnt != 16'd0) begin
              run_cnt <= run_cnt - 16'd1;
            end
            if (run_cnt <= 16'd1) begin
              state <= RD_TOK;
            end
          end
        end
        default: begin
          state <= RD_TOK;
        end
      endcase

      // Frame accounting overrides the per-state next-state choice.
      if (write_S2) begin
        if (frame_end) begin
          pix_cnt    <= 16'd0;
          frame_done <= 1'b1;
          state      <= RD_TOK;
          if ((state == EMIT_ZERO) && (run_cnt > 16'd1)) begin
            // Zeros that spill past the frame boundary are dropped.
            run_cnt <= 16'd0;
            err     <= 1'b1;
          end
        end else begin
          pix_cnt <= pix_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_kernel_run_length_decode.sv
// Directed testbench for kernel_run_length_decode with pixelCount=4.
module tb_kernel_run_length_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] input_S1 = 16'd0;
  logic        avail_S1 = 1'b0;
  logic        read_S1;
  logic [15:0] output_S2;
  logic        write_S2;
  logic        full_S2 = 1'b0;
  logic        running;
  logic        frame_done;
  logic        err;

  kernel_run_length_decode #(.pixelCount(4)) dut (
    .clk(clk), .rst(rst), .input_S1(input_S1), .avail_S1(avail_S1),
    .read_S1(read_S1), .output_S2(output_S2), .write_S2(write_S2),
    .full_S2(full_S2), .running(running), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] tok [0:15];
  int          tok_len = 0;
  int          tok_ptr = 0;
  bit          avail_en = 1'b1;
  int          full_lo = 0;
  int          full_hi = 0;
  logic [15:0] outv [0:31];
  int          outc [0:31];
  int          n_out = 0;
  int          n_fd = 0;
  int          fd_cyc = -1;
  int          cyc = 0;
  int          stall_wr = 0;
  logic        run_s = 1'b0;

  // One clock cycle: drive inputs, sample at negedge, pop on a read.
  task automatic tick();
    logic rd;
    input_S1 = (tok_ptr < tok_len) ? tok[tok_ptr] : 16'd0;
    avail_S1 = avail_en && (tok_ptr < tok_len);
    full_S2  = (cyc >= full_lo) && (cyc < full_hi);
    @(negedge clk);
    if (write_S2 && n_out < 32) begin
      outv[n_out] = output_S2;
      outc[n_out] = cyc;
      n_out++;
    end
    if (write_S2 && full_S2) stall_wr++;
    if (frame_done) begin
      n_fd++;
      fd_cyc = cyc;
    end
    run_s = running;
    rd = read_S1;
    @(posedge clk);
    #1;
    if (rd) tok_ptr++;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_out = 0; n_fd = 0; fd_cyc = -1; cyc = 0; tok_ptr = 0; tok_len = 0;
    full_lo = 0; full_hi = 0; stall_wr = 0; avail_en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tok[0] = 16'd5; tok_len = 1; tok_ptr = 0; avail_S1 = 1'b1; input_S1 = 16'd5;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (read_S1 !== 1'b0) begin n_fail++; $display("FAIL reset_read got=%b exp=0", read_S1); end
    n_chk++; if (write_S2 !== 1'b0) begin n_fail++; $display("FAIL reset_write got=%b exp=0", write_S2); end
    n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    n_chk++; if (running !== 1'b1) begin n_fail++; $display("FAIL reset_running got=%b exp=1", running); end
    @(posedge clk); #1;
  endtask

  task automatic test_literals();
    int ev [0:3];
    int ec [0:3];
    ev = '{5, 7, 9, 11};
    ec = '{1, 3, 5, 7};
    do_reset();
    tok[0] = 16'd5; tok[1] = 16'd7; tok[2] = 16'd9; tok[3] = 16'd11; tok_len = 4;
    repeat (10) tick();
    n_chk++; if (n_out !== 4) begin n_fail++; $display("FAIL lit_count got=%0d exp=4", n_out); end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (outv[i] !== 16'(ev[i]) || outc[i] !== ec[i]) begin
        n_fail++; $display("FAIL lit_pix%0d got=%0d@%0d exp=%0d@%0d", i, outv[i], outc[i], ev[i], ec[i]);
      end
    end
    n_chk++; if (n_fd !== 1 || fd_cyc !== 8) begin n_fail++; $display("FAIL lit_fd got=%0d@%0d exp=1@8", n_fd, fd_cyc); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL lit_err got=%b exp=0", err); end
  endtask

  task automatic test_run();
    int ev [0:3];
    int ec [0:3];
    ev = '{0, 0, 0, 25};
    ec = '{2, 3, 4, 6};
    do_reset();
    tok[0] = 16'd0; tok[1] = 16'd3; tok[2] = 16'd25; tok_len = 3;
    repeat (9) tick();
    n_chk++; if (n_out !== 4) begin n_fail++; $display("FAIL run_count got=%0d exp=4", n_out); end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (outv[i] !== 16'(ev[i]) || outc[i] !== ec[i]) begin
        n_fail++; $display("FAIL run_pix%0d got=%0d@%0d exp=%0d@%0d", i, outv[i], outc[i], ev[i], ec[i]);
      end
    end
    n_chk++; if (n_fd !== 1 || fd_cyc !== 7) begin n_fail++; $display("FAIL run_fd got=%0d@%0d exp=1@7", n_fd, fd_cyc); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL run_err got=%b exp=0", err); end
  endtask

  task automatic test_zero_count();
    do_reset();
    tok[0] = 16'd0; tok[1] = 16'd0; tok[2] = 16'd8; tok[3] = 16'd9;
    tok[4] = 16'd10; tok[5] = 16'd11; tok_len = 6;
    repeat (12) tick();
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL zc_err got=%b exp=1", err); end
    n_chk++; if (outv[0] !== 16'd8 || outc[0] !== 3) begin n_fail++; $display("FAIL zc_first got=%0d@%0d exp=8@3", outv[0], outc[0]); end
    n_chk++; if (n_out !== 4 || outv[3] !== 16'd11) begin n_fail++; $display("FAIL zc_count got=%0d last=%0d exp=4 last=11", n_out, outv[3]); end
    n_chk++; if (n_fd !== 1 || fd_cyc !== 10) begin n_fail++; $display("FAIL zc_fd got=%0d@%0d exp=1@10", n_fd, fd_cyc); end
  endtask

  task automatic test_overrun();
    int ev [0:8];
    int ec [0:8];
    ev = '{0, 0, 0, 0, 7, 9, 11, 13, 0};
    ec = '{2, 3, 4, 5, 7, 9, 11, 13, 0};
    do_reset();
    tok[0] = 16'd0; tok[1] = 16'd6; tok[2] = 16'd7; tok[3] = 16'd9;
    tok[4] = 16'd11; tok[5] = 16'd13; tok_len = 6;
    repeat (7) tick();
    n_chk++; if (n_fd !== 1 || fd_cyc !== 6) begin n_fail++; $display("FAIL ov_fd1 got=%0d@%0d exp=1@6", n_fd, fd_cyc); end
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL ov_err got=%b exp=1", err); end
    repeat (9) tick();
    n_chk++; if (n_out !== 8) begin n_fail++; $display("FAIL ov_count got=%0d exp=8", n_out); end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (outv[i] !== 16'(ev[i]) || outc[i] !== ec[i]) begin
        n_fail++; $display("FAIL ov_pix%0d got=%0d@%0d exp=%0d@%0d", i, outv[i], outc[i], ev[i], ec[i]);
      end
    end
    n_chk++; if (n_fd !== 2 || fd_cyc !== 14) begin n_fail++; $display("FAIL ov_fd2 got=%0d@%0d exp=2@14", n_fd, fd_cyc); end
  endtask

  task automatic test_full_stall();
    int ev [0:3];
    int ec [0:3];
    ev = '{0, 0, 0, 25};
    ec = '{2, 8, 9, 11};
    do_reset();
    full_lo = 3; full_hi = 8;
    tok[0] = 16'd0; tok[1] = 16'd3; tok[2] = 16'd25; tok_len = 3;
    repeat (14) tick();
    n_chk++; if (stall_wr !== 0) begin n_fail++; $display("FAIL fs_stallwr got=%0d exp=0", stall_wr); end
    n_chk++; if (n_out !== 4) begin n_fail++; $display("FAIL fs_count got=%0d exp=4", n_out); end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (outv[i] !== 16'(ev[i]) || outc[i] !== ec[i]) begin
        n_fail++; $display("FAIL fs_pix%0d got=%0d@%0d exp=%0d@%0d", i, outv[i], outc[i], ev[i], ec[i]);
      end
    end
    n_chk++; if (n_fd !== 1 || fd_cyc !== 12) begin n_fail++; $display("FAIL fs_fd got=%0d@%0d exp=1@12", n_fd, fd_cyc); end
  endtask

  task automatic test_stall_reset();
    do_reset();
    tick();
    tick();
    n_chk++; if (run_s !== 1'b0) begin n_fail++; $display("FAIL sr_running got=%b exp=0", run_s); end
    tok[0] = 16'd0; tok[1] = 16'd10; tok_len = 2; tok_ptr = 0;
    repeat (4) tick();
    n_chk++; if (n_out !== 2) begin n_fail++; $display("FAIL sr_prezeros got=%0d exp=2", n_out); end
    rst = 1'b1;
    tick();
    n_chk++; if (n_out !== 2) begin n_fail++; $display("FAIL sr_write_in_rst got=%0d exp=2", n_out); end
    rst = 1'b0;
    n_out = 0; n_fd = 0; fd_cyc = -1; cyc = 0; tok_ptr = 0;
    tok[0] = 16'd5; tok[1] = 16'd7; tok[2] = 16'd9; tok[3] = 16'd11; tok_len = 4;
    repeat (10) tick();
    n_chk++; if (n_out !== 4 || outv[0] !== 16'd5 || outc[0] !== 1) begin
      n_fail++; $display("FAIL sr_after got=%0d first=%0d@%0d exp=4 first=5@1", n_out, outv[0], outc[0]);
    end
    n_chk++; if (n_fd !== 1 || fd_cyc !== 8) begin n_fail++; $display("FAIL sr_fd got=%0d@%0d exp=1@8", n_fd, fd_cyc); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL sr_err got=%b exp=0", err); end
  endtask

  initial begin
    test_reset();
    test_literals();
    test_run();
    test_zero_count();
    test_overrun();
    test_full_stall();
    test_stall_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
